// File: rtl/airclk_keybuf.sv
// Digit-entry buffer for a keypad: keys shift into a live buffer and can be
// removed, committed, cleared, or aborted after a period with no key activity.
module airclk_keybuf #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_KEY    = 9,
    parameter int TIMEOUT_S  = 10
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          shift,
    input  logic [DIGIT_W-1:0]            key,
    input  logic                          backspace,
    input  logic                          commit,
    input  logic                          clear,
    input  logic                          one_sec,
    output logic [NUM_DIGITS*DIGIT_W-1:0] key_buf,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
    output logic                          entry_active,
    output logic [NUM_DIGITS*DIGIT_W-1:0] key_out,
    output logic                          key_out_valid,
    output logic                          key_reject,
    output logic                          entry_timeout
);

    localparam int BUF_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_S + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ENTRY = 1'b1;

    localparam logic [31:0]      MAX_KEY_U  = 32'(MAX_KEY);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(NUM_DIGITS);
    localparam logic [TMR_W-1:0] LAST_TICK  = TMR_W'(TIMEOUT_S - 1);

    logic [0:0]       state_q,   state_d;
    logic [BUF_W-1:0] buf_q,     buf_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [BUF_W-1:0] keyOut_q,  keyOut_d;
    logic             valid_q,   valid_d;
    logic             reject_q,  reject_d;
    logic             timeout_q, timeout_d;

    logic keyLegal;
    logic inEntry;

    assign keyLegal = ({{(32-DIGIT_W){1'b0}}, key} <= MAX_KEY_U);
    assign inEntry  = (state_q == ENTRY);

    // Strobes in a fixed priority chain; commit/backspace only win in ENTRY.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        count_d   = count_q;
        timer_d   = timer_q;
        keyOut_d  = keyOut_q;
        valid_d   = 1'b0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;

        if (clear) begin
            buf_d   = '0;
            count_d = '0;
            timer_d = '0;
            state_d = IDLE;
        end else if (commit && inEntry) begin
            keyOut_d = buf_q;
            valid_d  = 1'b1;
            buf_d    = '0;
            count_d  = '0;
            timer_d  = '0;
            state_d  = IDLE;
        end else if (backspace && inEntry) begin
            buf_d   = {{DIGIT_W{1'b0}}, buf_q[BUF_W-1:DIGIT_W]};
            count_d = count_q - CNT_W'(1);
            timer_d = '0;
            if (count_q == CNT_W'(1)) begin
                state_d = IDLE;
            end
        end else if (shift) begin
            if (keyLegal) begin
                buf_d   = {buf_q[BUF_W-DIGIT_W-1:0], key};
                count_d = (count_q == FULL_CNT) ? count_q : count_q + CNT_W'(1);
                timer_d = '0;
                state_d = ENTRY;
            end else begin
                reject_d = 1'b1;
            end
        end else if (one_sec && inEntry) begin
            if (timer_q == LAST_TICK) begin
                buf_d     = '0;
                count_d   = '0;
                timer_d   = '0;
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            keyOut_q  <= '0;
            valid_q   <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            keyOut_q  <= keyOut_d;
            valid_q   <= valid_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
        end
    end

    assign key_buf       = buf_q;
    assign digit_count   = count_q;
    assign entry_active  = inEntry;
    assign key_out       = keyOut_q;
    assign key_out_valid = valid_q;
    assign key_reject    = reject_q;
    assign entry_timeout = timeout_q;

endmodule

// File: tb/tb_airclk_keybuf.sv
// Directed plus randomized bench for airclk_keybuf against a queue-of-digits
// reference model (default parameters).
module tb_airclk_keybuf;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        shift;
    logic [3:0]  key;
    logic        backspace;
    logic        commit;
    logic        clear;
    logic        one_sec;
    logic [15:0] key_buf;
    logic [2:0]  digit_count;
    logic        entry_active;
    logic [15:0] key_out;
    logic        key_out_valid;
    logic        key_reject;
    logic        entry_timeout;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: digits held oldest-first, plus seconds since last activity.
    int          digits[$];
    int          idleSecs;
    logic [15:0] keyOutM;
    bit          validM, rejectM, timeoutM;

    airclk_keybuf dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .shift         (shift),
        .key           (key),
        .backspace     (backspace),
        .commit        (commit),
        .clear         (clear),
        .one_sec       (one_sec),
        .key_buf       (key_buf),
        .digit_count   (digit_count),
        .entry_active  (entry_active),
        .key_out       (key_out),
        .key_out_valid (key_out_valid),
        .key_reject    (key_reject),
        .entry_timeout (entry_timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] bufValue();
        logic [15:0] v = '0;
        foreach (digits[i]) v = v * 16 + 16'(digits[i]);
        return v;
    endfunction

    task automatic modelReset();
        digits.delete();
        idleSecs = 0;
        keyOutM  = '0;
        validM   = 0;
        rejectM  = 0;
        timeoutM = 0;
    endtask

    task automatic modelStep(input bit s, input int k, input bit b, input bit c,
                             input bit cl, input bit t);
        bit active = (digits.size() > 0);
        validM   = 0;
        rejectM  = 0;
        timeoutM = 0;
        if (cl) begin
            digits.delete();
            idleSecs = 0;
        end else if (c && active) begin
            keyOutM = bufValue();
            validM  = 1;
            digits.delete();
            idleSecs = 0;
        end else if (b && active) begin
            void'(digits.pop_back());
            idleSecs = 0;
        end else if (s) begin
            if (k <= 9) begin
                digits.push_back(k);
                if (digits.size() > 4) void'(digits.pop_front());
                idleSecs = 0;
            end else begin
                rejectM = 1;
            end
        end else if (t && active) begin
            idleSecs++;
            if (idleSecs == 10) begin
                digits.delete();
                idleSecs = 0;
                timeoutM = 1;
            end
        end
    endtask

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".key_buf"},       32'(key_buf),       32'(bufValue()));
        checkField({tag, ".digit_count"},   32'(digit_count),   32'(digits.size()));
        checkField({tag, ".entry_active"},  32'(entry_active),  32'(digits.size() > 0));
        checkField({tag, ".key_out"},       32'(key_out),       32'(keyOutM));
        checkField({tag, ".key_out_valid"}, 32'(key_out_valid), 32'(validM));
        checkField({tag, ".key_reject"},    32'(key_reject),    32'(rejectM));
        checkField({tag, ".entry_timeout"}, 32'(entry_timeout), 32'(timeoutM));
    endtask

    task automatic applyStimulus(input string tag, input bit s, input int k, input bit b,
                                 input bit c, input bit cl, input bit t);
        @(negedge clock);
        shift     = s;
        key       = 4'(k);
        backspace = b;
        commit    = c;
        clear     = cl;
        one_sec   = t;
        @(posedge clock);
        #1;
        shift = 0; backspace = 0; commit = 0; clear = 0; one_sec = 0;
        modelStep(s, k, b, c, cl, t);
        checkOutput(tag);
    endtask

    task automatic pressKey(input string tag, input int k);
        applyStimulus(tag, 1, k, 0, 0, 0, 0);
    endtask

    task automatic tick(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset_n = 0; shift = 0; key = 0; backspace = 0; commit = 0; clear = 0; one_sec = 0;
        modelReset();
        repeat (2) @(posedge clock);
        #1 checkOutput("reset");
        @(negedge clock) reset_n = 1;

        // First edge after release accepts keys; roll-over when full.
        pressKey("s1", 1); pressKey("s2", 2); pressKey("s3", 3); pressKey("s0", 0);
        checkField("roll.pre", 32'(key_buf), 32'h1230);
        pressKey("s5", 5);
        checkField("roll.post", 32'(key_buf), 32'h2305);
        applyStimulus("clr", 0, 0, 0, 0, 1, 0);

        pressKey("b.s1", 1); pressKey("b.s2", 2);
        applyStimulus("bs1", 0, 0, 1, 0, 0, 0);
        checkField("bs1.val", 32'(key_buf), 32'h0001);
        applyStimulus("bs2", 0, 0, 1, 0, 0, 0);
        checkField("bs2.idle", 32'(entry_active), 32'h0);
        applyStimulus("bs.idle", 0, 0, 1, 0, 0, 0);
        applyStimulus("cm.idle", 0, 0, 0, 1, 0, 0);

        // Rejected key in the middle of a countdown must not restart the timer.
        pressKey("r.s7", 7);
        for (int i = 0; i < 5; i++) tick("r.tick");
        pressKey("r.badA", 10);
        checkField("r.pulse", 32'(key_reject), 32'h1);
        for (int i = 0; i < 5; i++) tick("r.tick2");
        checkField("r.timeout", 32'(entry_timeout), 32'h1);

        pressKey("c.s1", 1); pressKey("c.s2", 2); pressKey("c.s3", 3); pressKey("c.s4", 4);
        applyStimulus("c.commit7", 1, 7, 0, 1, 0, 0);
        checkField("c.keyout", 32'(key_out), 32'h1234);
        applyStimulus("c.after", 0, 0, 0, 0, 0, 0);

        // Timeout with a shift landing on the 9th tick.
        pressKey("t.s7", 7);
        for (int i = 0; i < 8; i++) tick("t.tick");
        applyStimulus("t.shift9", 1, 3, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) tick("t.tickB");
        checkField("t.noto", 32'(entry_active), 32'h1);
        tick("t.tick10");
        checkField("t.to", 32'(entry_timeout), 32'h1);
        checkField("t.keyout", 32'(key_out), 32'h1234);

        // Asynchronous reset mid-entry.
        pressKey("m.s8", 8); pressKey("m.s9", 9);
        @(negedge clock);
        #2 reset_n = 0;
        #1 modelReset();
        checkOutput("midreset");
        @(negedge clock) reset_n = 1;

        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(99);
            applyStimulus("rand",
                          $urandom_range(99) < 50, $urandom_range(15),
                          $urandom_range(99) < 10, $urandom_range(99) < 8,
                          r < 4, $urandom_range(99) < 40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
